alu_ctrl_unit: RTL and testbench

//  Multi-cycle control unit sitting directly upstream of the registered ALU (alu_op/in1/in2 -> alu_out, z).

---
 rtl/alu_ctrl_unit.sv | 155 +++++++++++++++
 tb/tb_alu_ctrl_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: multi-cycle fetch/decode/execute controller that drives a
// registered ALU. It owns a 4-entry register bank, a program counter and a
// zero flag, and reports OUT instruction results on a pulsed output port.
module alu_ctrl_unit #(
  parameter int N    = 16,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [2:0]      alu_op,
  output logic [N-1:0]    alu_in1,
  output logic [N-1:0]    alu_in2,
  input  logic [N-1:0]    alu_out,
  input  logic [15:0]     alu_z,
  output logic [N-1:0]    out_data,
  output logic            out_valid,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_JPZ  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            r_state;
  state_t            w_next;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [N-1:0]      r_regs [4];
  logic              r_zflag;
  logic [N-1:0]      r_out_data;
  logic              r_out_valid;

  logic [3:0]        w_op;
  logic [1:0]        w_rd;
  logic [1:0]        w_rs1;
  logic [1:0]        w_rs2;
  logic [7:0]        w_imm;
  logic              w_is_alu;
  logic [PC_W-1:0]   w_target;
  logic              w_unused_z;

  // Instruction fields come from the latched instruction register, which is
  // stable from the end of DECODE until the next DECODE.
  assign w_op       = r_ir[15:12];
  assign w_rd       = r_ir[11:10];
  assign w_rs1      = r_ir[9:8];
  assign w_rs2      = r_ir[7:6];
  assign w_imm      = r_ir[7:0];
  assign w_is_alu   = (w_op >= 4'h1) && (w_op <= 4'h4);
  assign w_target   = PC_W'(w_imm);
  assign w_unused_z = ^alu_z[15:1];

  // The ROM registers its address at the end of FETCH, so the address port
  // simply shows the program counter; data is then valid during DECODE.
  assign imem_addr = r_pc;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: ALU ops take the WAIT/WB detour, HALT parks the unit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_op == OP_HALT) w_next = S_HALT;
        else if (w_is_alu)   w_next = S_WAIT;
        else                 w_next = S_FETCH;
      end
      S_WAIT:   w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   if (start) w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs: the ALU sees a non-zero op only in EXEC of an ALU instruction,
  // so its registered result holds through WAIT and WB.
  always_comb begin
    alu_op  = 3'd0;
    alu_in1 = '0;
    alu_in2 = '0;
    busy    = (r_state != S_IDLE) && (r_state != S_HALT);
    halted  = (r_state == S_HALT);
    if (r_state == S_EXEC && w_is_alu) begin
      alu_op  = w_op[2:0];
      alu_in1 = r_regs[w_rs1];
      alu_in2 = r_regs[w_rs2];
    end
  end

  // Datapath: pc, instruction register, register bank, zero flag, OUT port.
  // Operands are read in EXEC and the result lands at the end of WAIT, so
  // rd overlapping rs1/rs2 needs no special handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_zflag     <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) r_pc <= '0;
        end
        S_DECODE: begin
          r_ir <= imem_data;
          r_pc <= r_pc + 1'b1;
        end
        S_EXEC: begin
          case (w_op)
            OP_LDI: r_regs[w_rd] <= N'(w_imm);
            OP_JPZ: if (r_zflag) r_pc <= w_target;
            OP_JMP: r_pc <= w_target;
            OP_OUT: begin
              r_out_data  <= r_regs[w_rs1];
              r_out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        S_WAIT: r_regs[w_rd] <= alu_out;
        S_WB:   r_zflag <= alu_z[0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Testbench for alu_ctrl_unit: synchronous-read ROM, registered ALU, an
// instruction-level reference model and a per-cycle compare process.
module tb_alu_ctrl_unit;

  localparam int N    = 16;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data = '0;
  logic [2:0]      alu_op;
  logic [N-1:0]    alu_in1;
  logic [N-1:0]    alu_in2;
  logic [N-1:0]    alu_out = '0;
  logic [15:0]     alu_z = '0;
  logic [N-1:0]    out_data;
  logic            out_valid;
  logic            busy;
  logic            halted;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int alu_cnt  = 0;
  logic [15:0] last_out = '0;

  logic [15:0] rom [256];

  alu_ctrl_unit #(.N(N), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_z(alu_z),
    .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [2:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    case (op)
      3'd1: r = a + b;
      3'd2: r = a - b;
      3'd3: r = a * b;
      3'd4: r = a << b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 6'b000000};
  endfunction

  function automatic logic [15:0] insi(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [7:0] imm);
    return {op, rd, 2'b00, imm};
  endfunction

  // Synchronous-read instruction ROM.
  always @(posedge clk) imem_data <= rom[imem_addr];

  // Registered ALU: result one cycle after issue, zero flag one cycle later.
  always @(posedge clk) begin
    if (alu_op != 3'd0) alu_out <= alu_fn(alu_op, alu_in1, alu_in2);
    alu_z <= {15'b0, (alu_out == 16'h0000)};
  end

  // ---------------- reference model (instruction level) ----------------
  logic        m_run, m_halt, m_ov, m_z;
  logic [15:0] m_od;
  logic [7:0]  m_pc;
  int          m_cyc;
  logic [15:0] m_regs [4];
  logic [15:0] m_w;
  logic [3:0]  m_op;
  logic [1:0]  m_rd, m_rs1, m_rs2;
  logic [7:0]  m_imm, m_npc;
  logic        m_alu;
  int          m_lat;

  assign m_w   = rom[m_pc];
  assign m_op  = m_w[15:12];
  assign m_rd  = m_w[11:10];
  assign m_rs1 = m_w[9:8];
  assign m_rs2 = m_w[7:6];
  assign m_imm = m_w[7:0];
  assign m_alu = (m_op >= 4'h1) && (m_op <= 4'h4);
  assign m_lat = m_alu ? 5 : 3;
  assign m_npc = (m_op == 4'h7 || (m_op == 4'h6 && m_z)) ? m_imm : m_pc + 8'd1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_halt <= 1'b0; m_ov <= 1'b0; m_z <= 1'b0;
      m_od <= '0; m_pc <= '0; m_cyc <= 0;
      for (int i = 0; i < 4; i++) m_regs[i] <= '0;
    end else begin
      m_ov <= 1'b0;
      if (!m_run) begin
        if (start) begin
          m_run <= 1'b1; m_halt <= 1'b0; m_pc <= '0; m_cyc <= 0;
        end
      end else begin
        if (m_cyc == 2 && m_op == 4'h5) m_regs[m_rd] <= {8'h00, m_imm};
        if (m_cyc == 2 && m_op == 4'h8) begin
          m_ov <= 1'b1;
          m_od <= m_regs[m_rs1];
        end
        if (m_alu && m_cyc == 3)
          m_regs[m_rd] <= alu_fn(m_op[2:0], m_regs[m_rs1], m_regs[m_rs2]);
        if (m_alu && m_cyc == 4) m_z <= (m_regs[m_rd] == 16'h0000);
        if (m_cyc == m_lat - 1) begin
          m_cyc <= 0;
          m_pc  <= m_npc;
          if (m_op == 4'hF) begin
            m_run  <= 1'b0;
            m_halt <= 1'b1;
          end
        end else begin
          m_cyc <= m_cyc + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, plus output/ALU activity tally.
  always @(negedge clk) begin
    if (!rst) begin
      logic       act;
      logic [2:0] e_op;
      act  = m_run && (m_cyc == 2) && m_alu;
      e_op = act ? m_op[2:0] : 3'd0;
      chk("busy", busy, m_run);
      chk("halted", halted, m_halt);
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      chk("alu_op", alu_op, e_op);
      chk("imem_addr_known", $isunknown(imem_addr), 1'b0);
      if (act) begin
        chk("alu_in1", alu_in1, m_regs[m_rs1]);
        chk("alu_in2", alu_in2, m_regs[m_rs2]);
      end
      if (m_run && m_cyc == 0) chk("imem_addr", imem_addr, m_pc);
      if (out_valid) begin
        n_out++;
        last_out = out_data;
      end
      if (alu_op != 3'd0) alu_cnt++;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run_prog(input bit extra_start);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (extra_start) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk("halt_reached", halted, 1'b1);
    @(posedge clk); #2;
  endtask

  initial begin
    int o0, a0;
    rst = 1'b1;
    start = 1'b0;
    clear_rom();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_alu_op", alu_op, 3'd0);
    chk("rst_imem_addr", imem_addr, 8'h00);

    // 1: LDI/LDI/ADD/OUT/HALT
    rom[0] = insi(4'h5, 2'd0, 8'd5);
    rom[1] = insi(4'h5, 2'd1, 8'd3);
    rom[2] = ins(4'h1, 2'd2, 2'd0, 2'd1);
    rom[3] = ins(4'h8, 2'd0, 2'd2, 2'd0);
    rom[4] = 16'hF000;
    @(posedge clk); #1 rst = 1'b0;
    o0 = n_out;
    run_prog(1'b0);
    chk("t1_out", last_out, 16'd8);
    chk("t1_nout", n_out - o0, 1);
    chk("t1_model_od", m_od, 16'd8);
    chk("t1_halted", halted, 1'b1);

    // 2: JPZ taken after SUB gives zero; then restart from HALT
    clear_rom();
    rom[0]    = insi(4'h5, 2'd0, 8'd7);
    rom[1]    = ins(4'h2, 2'd1, 2'd0, 2'd0);
    rom[2]    = insi(4'h6, 2'd0, 8'h10);
    rom[8'h10] = ins(4'h8, 2'd0, 2'd0, 2'd0);
    rom[8'h11] = 16'hF000;
    do_reset();
    o0 = n_out;
    run_prog(1'b0);
    chk("t2_out", last_out, 16'd7);
    chk("t2_model_z", m_z, 1'b1);
    chk("t2_pc", imem_addr, 8'h12);
    run_prog(1'b0);
    chk("t2_restart_nout", n_out - o0, 2);
    chk("t2_restart_out", last_out, 16'd7);

    // 3: zflag cleared by later ADD -> JPZ not taken; extra start ignored
    clear_rom();
    rom[0]    = insi(4'h5, 2'd0, 8'd4);
    rom[1]    = ins(4'h2, 2'd1, 2'd0, 2'd0);
    rom[2]    = insi(4'h5, 2'd1, 8'd2);
    rom[3]    = ins(4'h1, 2'd2, 2'd0, 2'd1);
    rom[4]    = insi(4'h6, 2'd0, 8'h20);
    rom[5]    = ins(4'h8, 2'd0, 2'd2, 2'd0);
    rom[6]    = 16'hF000;
    rom[8'h20] = ins(4'h8, 2'd0, 2'd0, 2'd0);
    do_reset();
    o0 = n_out;
    run_prog(1'b1);
    chk("t3_out", last_out, 16'd6);
    chk("t3_nout", n_out - o0, 1);
    chk("t3_pc", imem_addr, 8'h07);

    // 4: MUL truncation and single-cycle ALU issue
    clear_rom();
    rom[0] = insi(4'h5, 2'd0, 8'hFF);
    rom[1] = ins(4'h3, 2'd1, 2'd0, 2'd0);
    rom[2] = ins(4'h8, 2'd0, 2'd1, 2'd0);
    rom[3] = 16'hF000;
    do_reset();
    a0 = alu_cnt;
    run_prog(1'b0);
    chk("t4_out", last_out, 16'hFE01);
    chk("t4_alu_cycles", alu_cnt - a0, 1);
    chk("t4_pc", imem_addr, 8'h04);

    // 5: JMP near top of memory, NOP at 0xFF, pc wraps to 0, then JPZ taken
    clear_rom();
    rom[0]    = insi(4'h6, 2'd0, 8'h05);
    rom[1]    = insi(4'h7, 2'd0, 8'hFE);
    rom[5]    = 16'hF000;
    rom[8'hFE] = ins(4'h2, 2'd0, 2'd0, 2'd0);
    rom[8'hFF] = 16'h0000;
    do_reset();
    run_prog(1'b0);
    chk("t5_model_pc", m_pc, 8'h06);
    chk("t5_pc", imem_addr, 8'h06);
    chk("t5_halted", halted, 1'b1);

    // 6: reset during WAIT of ADD discards the write-back
    clear_rom();
    rom[0] = insi(4'h5, 2'd0, 8'd5);
    rom[1] = insi(4'h5, 2'd1, 8'd3);
    rom[2] = ins(4'h1, 2'd2, 2'd0, 2'd1);
    rom[3] = ins(4'h8, 2'd0, 2'd2, 2'd0);
    rom[4] = 16'hF000;
    do_reset();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (alu_op != 3'd0) break;
    end
    chk("t6_alu_issue", alu_op, 3'd1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_halted", halted, 1'b0);
    chk("t6_imem_addr", imem_addr, 8'h00);
    chk("t6_alu_op", alu_op, 3'd0);
    clear_rom();
    rom[0] = ins(4'h8, 2'd0, 2'd2, 2'd0);
    rom[1] = 16'hF000;
    @(posedge clk); #1 rst = 1'b0;
    o0 = n_out;
    last_out = 16'hDEAD;
    run_prog(1'b0);
    chk("t6_r2_out", last_out, 16'h0000);
    chk("t6_nout", n_out - o0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
